// File: rtl/pwm_audio_pkg.sv
// pwm_audio_pkg: shared scheduler state encoding and sample/duty helpers
package pwm_audio_pkg;
    typedef enum logic [1:0] {IDLE, PRIME, RUN, RAMP} sched_state_t;
    function automatic int mid(input int n);
        return 1 << (n - 1);
    endfunction
    function automatic int sample_to_duty(input int s, input int w, input int n);
        return (s >>> (w - n)) + mid(n);
    endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous sample buffer with flush and occupancy count
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    // a full buffer refuses the push even when a pop frees a slot this cycle
    assign do_push = push && !full && !flush;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/pwm_sample_scheduler.sv
// pwm_sample_scheduler: paces signed samples into pwm_audio duty on period boundaries
module pwm_sample_scheduler import pwm_audio_pkg::*; #(
    parameter int N          = 10,
    parameter int W          = 16,
    parameter int PPS        = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int PRIME_LVL  = 2,
    parameter int RAMP_STEP  = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         mute,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [N:0]   duty_val,
    output logic         underrun,
    input  logic         clr_underrun,
    output logic [1:0]   state_o
);
    localparam int PW = PPS > 1 ? $clog2(PPS) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [N:0] MID = (N+1)'(mid(N));
    localparam logic [N:0] STEP = (N+1)'(RAMP_STEP);
    sched_state_t state, state_nx;
    logic [N-1:0] pcnt;
    logic [PW-1:0] per_cnt;
    logic [N:0] duty_nx, duty_ramp, head_duty;
    logic [W-1:0] head;
    logic [CW-1:0] count;
    logic period_end, tick, full, empty, pop, flush, primed;
    assign period_end = &pcnt;
    assign tick = period_end && per_cnt == PW'(PPS - 1);
    assign s_ready = !full && state != IDLE;
    assign flush = state == IDLE;
    assign primed = count >= CW'(PRIME_LVL);
    assign head_duty = (N+1)'(sample_to_duty(int'($signed(head)), W, N));
    assign state_o = state;
    // step toward midscale without overshooting it
    assign duty_ramp = duty_val > MID ? (duty_val - MID > STEP ? duty_val - STEP : MID)
                                      : (MID - duty_val > STEP ? duty_val + STEP : MID);
    sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(W)) u_fifo (
        .clk   (clk),
        .reset_n(reset_n),
        .push  (s_valid && s_ready),
        .pop   (pop),
        .flush (flush),
        .din   (s_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_comb begin
        state_nx = state;
        duty_nx = duty_val;
        pop = 1'b0;
        unique case (state)
            IDLE: begin
                duty_nx = MID;
                if (enable && !mute) state_nx = PRIME;
            end
            PRIME: begin
                duty_nx = MID;
                if (!enable) state_nx = IDLE;
                else if (tick && primed) begin
                    state_nx = RUN;
                    pop = 1'b1;
                    duty_nx = head_duty;
                end
            end
            RUN: begin
                pop = tick;
                if (tick && !empty) duty_nx = head_duty;
                if (mute || !enable) state_nx = RAMP;
            end
            RAMP: begin
                pop = tick;
                duty_nx = duty_ramp;
                if (!enable && duty_val == MID) state_nx = IDLE;
                else if (enable && !mute && tick) begin
                    state_nx = RUN;
                    if (!empty) duty_nx = head_duty;
                end
            end
        endcase
    end
    // duty only changes at period_end so pwm_audio sees it from pcnt==0
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state    <= IDLE;
            pcnt     <= '0;
            per_cnt  <= '0;
            duty_val <= MID;
            underrun <= 1'b0;
        end else begin
            state <= state_nx;
            pcnt  <= pcnt + N'(1);
            if (period_end) begin
                per_cnt  <= tick ? '0 : per_cnt + PW'(1);
                duty_val <= duty_nx;
            end
            underrun <= (tick && state == RUN && empty) || (underrun && !clr_underrun);
        end
endmodule
